// File: rtl/prog_lut_mux_pkg.sv
// Shared types and constants for the programmable truth-table multiplexer.
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sweep_state_t;

    localparam int unsigned LUT_SEL_W_DEFAULT = 3;

    function automatic int unsigned lut_depth(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

    localparam int unsigned LUT_N = lut_depth(LUT_SEL_W_DEFAULT);

    // Bit i is the function output for select value i.
    localparam logic [LUT_N-1:0] INIT_DEFAULT = 8'b1001_0110;

endpackage

// File: rtl/prog_lut_mux_if.sv
// Sweep stream: one truth-table entry per beat under a valid/ready handshake.
interface prog_lut_mux_if #(
    parameter int unsigned SEL_W = 3
);
    logic             sw_valid;
    logic             sw_ready;
    logic [SEL_W-1:0] sw_idx;
    logic             sw_bit;

    modport master (
        output sw_valid,
        output sw_idx,
        output sw_bit,
        input  sw_ready
    );

    modport slave (
        input  sw_valid,
        input  sw_idx,
        input  sw_bit,
        output sw_ready
    );
endinterface

// File: rtl/lut_sweep_ctrl.sv
// Sweep sequencer: walks every table index once under valid/ready, then pulses done.
module lut_sweep_ctrl
    import lut_pkg::*;
#(
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sw_ready,
    output logic             sw_valid,
    output logic [SEL_W-1:0] sw_idx,
    output logic             busy,
    output logic             done
);

    sweep_state_t     state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                // Explicit exit on the last index; the counter never wraps mid-sweep.
                if (sw_ready) begin
                    if (idx_q == '1) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign sw_valid = (state_q == SWEEP);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sw_idx   = idx_q;

endmodule

// File: rtl/prog_lut_mux.sv
// Programmable truth-table multiplexer with parallel/serial table load,
// registered strobed lookup and a handshaked table sweep.
module prog_lut_mux
    import lut_pkg::*;
#(
    parameter int unsigned             SEL_W = 3,
    parameter logic [(1<<SEL_W)-1:0]   INIT  = INIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sn,
    output logic                  y,
    input  logic                  tbl_load,
    input  logic [(1<<SEL_W)-1:0] tbl_din,
    input  logic                  tbl_shift,
    input  logic                  tbl_sin,
    output logic [(1<<SEL_W)-1:0] tbl_q,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    prog_lut_mux_if.master        sw
);

    localparam int unsigned N = 1 << SEL_W;

    logic [N-1:0]     table_q, table_d;
    logic             y_q, y_d;
    logic             sw_valid;
    logic [SEL_W-1:0] sw_idx;

    lut_sweep_ctrl #(
        .SEL_W (SEL_W)
    ) u_sweep (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sw_ready (sw.sw_ready),
        .sw_valid (sw_valid),
        .sw_idx   (sw_idx),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            table_q <= INIT;
            y_q     <= 1'b1;
        end else begin
            table_q <= table_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        table_d = table_q;
        if (!busy) begin
            if (tbl_load) begin
                table_d = tbl_din;
            end else if (tbl_shift) begin
                table_d = {table_q[N-2:0], tbl_sin};
            end
        end
    end

    // Lookup reads table_q, so a same-cycle table update is not visible yet.
    always_comb begin
        y_d = sn ? 1'b1 : table_q[sel];
    end

    assign y           = y_q;
    assign tbl_q       = table_q;
    assign sw.sw_valid = sw_valid;
    assign sw.sw_idx   = sw_idx;
    assign sw.sw_bit   = table_q[sw_idx];

endmodule
